mips_cpu_hilo_ctrl: RTL and testbench
=====================================

Name: mips_cpu_hilo_ctrl

Overview:
- Upstream issue/stall controller for the HI/LO multiply-divide unit.
- Accepts decoded R-type HI/LO instructions from the CPU datapath.
- Latches operands and drives the unit's opcode/a/b/valid_in, holding them for the full operation.
- Stalls the pipeline until completion, and serves mfhi/mflo results with stall on a busy unit.

Parameters:
- MULT_CYCLES, 3: cycles the mult/multu opcode is held before completion; covers the unit's product register staging.
- DIV_TIMEOUT, 40: maximum cycles waited for hilo_valid_out on div/divu before forced completion.
- SETTLE_CYCLES, 1: cycles the div/divu opcode is held after hilo_valid_out, to cover the sign-fixup write.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  decoded instruction present this cycle
- funct  in  6  R-type function field
- rs_val  in  32  rs operand
- rt_val  in  32  rt operand
- stall  out  1  freeze pipeline; instruction must be held unchanged while high
- mf_data  out  32  HI or LO value for mfhi/mflo
- mf_valid  out  1  mf_data valid this cycle
- timeout_err  out  1  sticky; div timed out
- hilo_opcode  out  6  opcode to HI/LO unit
- hilo_a  out  32  operand a to unit
- hilo_b  out  32  operand b to unit
- hilo_valid_in  out  1  div/divu start pulse
- hilo_valid_out  in  1  unit done flag (div paths)
- hilo_hi  in  32  unit HI
- hilo_lo  in  32  unit LO

Behaviour:
- Function codes:
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011
  - mult 011000, multu 011001, div 011010, divu 011011
  - All other funct values are ignored.
- Reset: state IDLE; hilo_opcode=000000 (no-op), hilo_a=hilo_b=0; hilo_valid_in, stall, mf_valid, timeout_err all 0; counter=0.
- Reset mid-operation: returns to IDLE next edge and drives the no-op opcode. HI/LO contents are not restored.
- hilo_opcode, hilo_a, hilo_b and hilo_valid_in are registered.
- stall, mf_data and mf_valid are combinational from state and the current inputs.
- FSM states: IDLE, MTX, MUL, DIV_START, DIV_RUN, DIV_SETTLE.
- IDLE:
  - mthi/mtlo: register opcode and a=rs_val; go to MTX. stall=0 (write commits on the next edge).
  - mult/multu: register opcode, a=rs_val, b=rt_val; counter=MULT_CYCLES-1; go to MUL. stall=1 in the issue cycle.
  - div/divu: register opcode, a, b; hilo_valid_in=1; go to DIV_START. stall=1.
  - mfhi/mflo: mf_data=hilo_hi or hilo_lo; mf_valid=1; stall=0.
- MTX: opcode returns to no-op; back to IDLE. A new instruction in this cycle is handled exactly as in IDLE, giving back-to-back issue.
- MUL:
  - stall=1; opcode and operands held.
  - counter decrements each cycle; at 0, opcode goes to no-op and the FSM returns to IDLE.
  - stall drops in the cycle the FSM is IDLE again.
- DIV_START: hilo_valid_in deasserted; counter=DIV_TIMEOUT; go to DIV_RUN. stall=1.
- DIV_RUN: stall=1; operands held; counter decrements.
  - hilo_valid_out=1: counter=SETTLE_CYCLES; go to DIV_SETTLE.
  - counter hits 0 first: set timeout_err; go to DIV_SETTLE.
- DIV_SETTLE: stall=1; counter decrements; at 0, opcode goes to no-op and the FSM returns to IDLE.
- mfhi/mflo while busy (any non-IDLE/MTX state): stall=1 and mf_valid=0 until IDLE.
- mfhi/mflo in MTX: returns the value just written; the write completes at the MTX-entry edge.
- Simultaneous events: only one instruction is accepted per cycle. While stall=1 the input instruction is ignored and must be re-presented by the held pipeline.
- timeout_err clears only on reset.

Optional Feature:
- Macro: MIPS_CPU_HILO_CTRL_DIV0_EN.
- Defined: div/divu with rt_val==0 is not launched. The FSM stays IDLE, stall=0, HI/LO are unchanged, and sticky output div0_flag (1-bit, reset 0) sets.
- Undefined: the div0_flag port is absent, and zero divisors are launched normally. Completion then relies on hilo_valid_out or the timeout.

Test Plan:
- mthi rs=0x12345678, then mfhi the next cycle -> mf_data=0x12345678, mf_valid=1, stall never asserted.
- multu rs=0xFFFFFFFF, rt=2 -> stall high for exactly MULT_CYCLES+1 cycles; then mfhi=0x00000001 and mflo=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9), rt=2 -> hilo_valid_in pulses 1 cycle; stall holds until hilo_valid_out plus 1 settle cycle; then mflo=0xFFFFFFFD and mfhi=0xFFFFFFFF.
- mflo presented during a divu 100/7 -> stall=1 and mf_valid=0 throughout; on release mf_data=14.
- Stub hilo_valid_out held 0 on divu -> after DIV_TIMEOUT+SETTLE_CYCLES cycles the FSM returns to IDLE and timeout_err=1. With MIPS_CPU_HILO_CTRL_DIV0_EN, divu by 0 -> no stall and div0_flag=1.
- Reset asserted mid-div -> next cycle hilo_opcode=000000, stall=0, timeout_err=0.

Source files
------------

// File: rtl/mips_cpu_hilo_ctrl.sv
// Issue/stall controller for the HI/LO multiply-divide unit: latches operands, holds the opcode, serves mfhi/mflo.
// Optional macro MIPS_CPU_HILO_CTRL_DIV0_EN: zero-divisor div/divu is dropped and reported on sticky div0_flag.
module mips_cpu_hilo_ctrl #(
   parameter int unsigned MULT_CYCLES   = 3,
   parameter int unsigned DIV_TIMEOUT   = 40,
   parameter int unsigned SETTLE_CYCLES = 1,
   localparam int unsigned FUNCT_W      = 6,
   localparam int unsigned DATA_W       = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [DATA_W-1:0]  rs_val,
   input  logic [DATA_W-1:0]  rt_val,
   output logic               stall,
   output logic [DATA_W-1:0]  mf_data,
   output logic               mf_valid,
   output logic               timeout_err,
   output logic [FUNCT_W-1:0] hilo_opcode,
   output logic [DATA_W-1:0]  hilo_a,
   output logic [DATA_W-1:0]  hilo_b,
   output logic               hilo_valid_in,
`ifdef MIPS_CPU_HILO_CTRL_DIV0_EN
   output logic               div0_flag,
`endif
   input  logic               hilo_valid_out,
   input  logic [DATA_W-1:0]  hilo_hi,
   input  logic [DATA_W-1:0]  hilo_lo
);

   localparam logic [FUNCT_W-1:0] OP_NOP  = 6'b000000;
   localparam logic [FUNCT_W-1:0] F_MFHI  = 6'b010000;
   localparam logic [FUNCT_W-1:0] F_MTHI  = 6'b010001;
   localparam logic [FUNCT_W-1:0] F_MFLO  = 6'b010010;
   localparam logic [FUNCT_W-1:0] F_MTLO  = 6'b010011;
   localparam logic [FUNCT_W-1:0] F_MULT  = 6'b011000;
   localparam logic [FUNCT_W-1:0] F_MULTU = 6'b011001;
   localparam logic [FUNCT_W-1:0] F_DIV   = 6'b011010;
   localparam logic [FUNCT_W-1:0] F_DIVU  = 6'b011011;

   localparam int unsigned CNT_MAX =
      (DIV_TIMEOUT > MULT_CYCLES)
         ? ((DIV_TIMEOUT > SETTLE_CYCLES) ? DIV_TIMEOUT : SETTLE_CYCLES)
         : ((MULT_CYCLES > SETTLE_CYCLES) ? MULT_CYCLES : SETTLE_CYCLES);
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MTX, S_MUL, S_DIV_START, S_DIV_RUN, S_DIV_SETTLE
   } state_e;

   state_e              state_q, state_d;
   logic [FUNCT_W-1:0]  opcode_q, opcode_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic                vin_q, vin_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tmo_q, tmo_d;

   logic is_mf, is_mt, is_mul, is_div, div_zero, div_go, accept_st;

   // Instruction decode; only IDLE and MTX accept new work
   assign is_mf     = instr_valid && ((funct == F_MFHI) || (funct == F_MFLO));
   assign is_mt     = instr_valid && ((funct == F_MTHI) || (funct == F_MTLO));
   assign is_mul    = instr_valid && ((funct == F_MULT) || (funct == F_MULTU));
   assign is_div    = instr_valid && ((funct == F_DIV)  || (funct == F_DIVU));
   assign accept_st = (state_q == S_IDLE) || (state_q == S_MTX);
`ifdef MIPS_CPU_HILO_CTRL_DIV0_EN
   assign div_zero  = is_div && (rt_val == '0);
`else
   assign div_zero  = 1'b0;
`endif
   assign div_go    = is_div && !div_zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opcode_q <= OP_NOP;
         a_q      <= '0;
         b_q      <= '0;
         vin_q    <= 1'b0;
         cnt_q    <= '0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         vin_q    <= vin_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      a_d      = a_q;
      b_d      = b_q;
      vin_d    = 1'b0;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      case (state_q)
         S_IDLE, S_MTX: begin
            state_d  = S_IDLE;
            opcode_d = OP_NOP;
            if (is_mt) begin
               opcode_d = funct;
               a_d      = rs_val;
               state_d  = S_MTX;
            end else if (is_mul) begin
               opcode_d = funct;
               a_d      = rs_val;
               b_d      = rt_val;
               cnt_d    = CNT_W'(MULT_CYCLES - 1);
               state_d  = S_MUL;
            end else if (div_go) begin
               opcode_d = funct;
               a_d      = rs_val;
               b_d      = rt_val;
               vin_d    = 1'b1;
               state_d  = S_DIV_START;
            end
         end
         S_MUL: begin
            if (cnt_q == '0) begin
               opcode_d = OP_NOP;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DIV_START: begin
            cnt_d   = CNT_W'(DIV_TIMEOUT);
            state_d = S_DIV_RUN;
         end
         // Done flag wins over a timeout landing in the same cycle
         S_DIV_RUN: begin
            if (hilo_valid_out) begin
               cnt_d   = CNT_W'(SETTLE_CYCLES);
               state_d = S_DIV_SETTLE;
            end else if (cnt_q <= CNT_W'(1)) begin
               tmo_d   = 1'b1;
               cnt_d   = CNT_W'(SETTLE_CYCLES);
               state_d = S_DIV_SETTLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DIV_SETTLE: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d    = '0;
               opcode_d = OP_NOP;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall    = 1'b1;
      mf_valid = 1'b0;
      mf_data  = '0;
      if (accept_st) begin
         stall = is_mul || div_go;
         if (is_mf) begin
            mf_valid = 1'b1;
            mf_data  = (funct == F_MFHI) ? hilo_hi : hilo_lo;
         end
      end
   end

   assign hilo_opcode   = opcode_q;
   assign hilo_a        = a_q;
   assign hilo_b        = b_q;
   assign hilo_valid_in = vin_q;
   assign timeout_err   = tmo_q;

`ifdef MIPS_CPU_HILO_CTRL_DIV0_EN
   logic div0_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         div0_q <= 1'b0;
      end else if (accept_st && div_zero) begin
         div0_q <= 1'b1;
      end
   end
   assign div0_flag = div0_q;
`endif

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Bench for mips_cpu_hilo_ctrl: HI/LO unit stub, transaction-level reference model, directed and random stimulus.
`timescale 1ns/1ps
module tb_mips_cpu_hilo_ctrl;
   localparam int unsigned MULT_CYCLES   = 3;
   localparam int unsigned DIV_TIMEOUT   = 40;
   localparam int unsigned SETTLE_CYCLES = 1;
   localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
   localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

   logic        clk = 1'b0, reset = 1'b1, instr_valid = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] rs_val = '0, rt_val = '0;
   logic        stall, mf_valid, timeout_err, hilo_valid_in;
   logic [31:0] mf_data, hilo_a, hilo_b, hilo_hi, hilo_lo;
   logic [5:0]  hilo_opcode;
   logic        hilo_valid_out = 1'b0;
`ifdef MIPS_CPU_HILO_CTRL_DIV0_EN
   logic        div0_flag;
`endif

   mips_cpu_hilo_ctrl #(
      .MULT_CYCLES(MULT_CYCLES), .DIV_TIMEOUT(DIV_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .funct(funct),
      .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .mf_data(mf_data),
      .mf_valid(mf_valid), .timeout_err(timeout_err), .hilo_opcode(hilo_opcode),
      .hilo_a(hilo_a), .hilo_b(hilo_b), .hilo_valid_in(hilo_valid_in),
`ifdef MIPS_CPU_HILO_CTRL_DIV0_EN
      .div0_flag(div0_flag),
`endif
      .hilo_valid_out(hilo_valid_out), .hilo_hi(hilo_hi), .hilo_lo(hilo_lo)
   );

   always #5 clk = ~clk;

   int n_total = 0, n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // MIPS HI/LO results: mult -> {hi,lo} product, div -> lo quotient / hi remainder
   function automatic void hilo_calc(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
      logic signed [31:0] sa, sb;
      logic signed [63:0] xa, xb, sp;
      logic [63:0] up;
      sa = a; sb = b; xa = sa; xb = sb;
      hi = '0; lo = '0;
      case (op)
         MULT:  begin sp = xa * xb; hi = sp[63:32]; lo = sp[31:0]; end
         MULTU: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
         DIV:   begin lo = sa / sb; hi = sa % sb; end
         DIVU:  begin lo = a / b; hi = a % b; end
         default: ;
      endcase
   endfunction

   // HI/LO unit stub; mthi/mtlo are write-through so MTX reads see the new value
   logic [31:0] st_hi = '0, st_lo = '0;
   int          st_cnt = -1, div_lat = 2;
   bit          st_hang = 1'b0;
   assign hilo_hi = (hilo_opcode == MTHI) ? hilo_a : st_hi;
   assign hilo_lo = (hilo_opcode == MTLO) ? hilo_a : st_lo;

   always @(posedge clk) begin : stub
      logic [31:0] rh, rl;
      hilo_valid_out <= 1'b0;
      if (reset) begin
         st_cnt <= -1;
      end else begin
         if (hilo_opcode == MTHI) st_hi <= hilo_a;
         if (hilo_opcode == MTLO) st_lo <= hilo_a;
         if (hilo_opcode == MULT || hilo_opcode == MULTU) begin
            hilo_calc(hilo_opcode, hilo_a, hilo_b, rh, rl);
            st_hi <= rh; st_lo <= rl;
         end
         if (hilo_valid_in) st_cnt <= div_lat;
         else if (st_cnt > 0) st_cnt <= st_cnt - 1;
         else if (st_cnt == 0) begin
            st_cnt <= -1;
            if (!st_hang) begin
               hilo_calc(hilo_opcode, hilo_a, hilo_b, rh, rl);
               hilo_valid_out <= 1'b1;
               st_hi <= rh; st_lo <= rl;
            end
         end
      end
   end

   // Reference model: one transaction at a time, tracked by its age in cycles since issue
   logic [5:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
   bit          m_vin = 0, m_tmo = 0, m_div0 = 0, m_ok = 0;
   int          m_kind = 0, m_age = 0, m_evt = -1;

   always @(negedge clk) begin : model
      bit busy, is_mf, is_mt, is_mul, is_div, div_go, e_stall, e_mfv;
      if (chk_en) begin
         busy   = (m_kind != 0);
         is_mf  = instr_valid && (funct == MFHI || funct == MFLO);
         is_mt  = instr_valid && (funct == MTHI || funct == MTLO);
         is_mul = instr_valid && (funct == MULT || funct == MULTU);
         is_div = instr_valid && (funct == DIV  || funct == DIVU);
         div_go = is_div;
`ifdef MIPS_CPU_HILO_CTRL_DIV0_EN
         if (rt_val == 32'd0) div_go = 1'b0;
         chk("div0_flag", div0_flag, m_div0);
`endif
         e_stall = busy || is_mul || div_go;
         e_mfv   = !busy && is_mf;
         chk("stall", stall, e_stall);
         chk("mf_valid", mf_valid, e_mfv);
         if (e_mfv) chk("mf_data", mf_data, (funct == MFHI) ? m_hi : m_lo);
         chk("hilo_opcode", hilo_opcode, m_op);
         chk("hilo_a", hilo_a, m_a);
         chk("hilo_b", hilo_b, m_b);
         chk("hilo_valid_in", hilo_valid_in, m_vin);
         chk("timeout_err", timeout_err, m_tmo);

         if (reset) begin
            m_op = '0; m_a = '0; m_b = '0; m_vin = 0; m_tmo = 0; m_div0 = 0; m_kind = 0;
         end else if (busy) begin
            m_vin = 0;
            if (m_kind == 1) begin
               if (m_age + 1 > MULT_CYCLES) begin
                  m_kind = 0; m_op = '0; m_hi = m_rhi; m_lo = m_rlo;
               end
            end else begin
               if (m_evt < 0 && m_age >= 2) begin
                  if (hilo_valid_out) begin m_evt = m_age; m_ok = 1; end
                  else if (m_age == 1 + DIV_TIMEOUT) begin m_evt = m_age; m_ok = 0; m_tmo = 1; end
               end
               if (m_evt >= 0 && m_age + 1 == m_evt + SETTLE_CYCLES + 1) begin
                  m_kind = 0; m_op = '0;
                  if (m_ok) begin m_hi = m_rhi; m_lo = m_rlo; end
               end
            end
            m_age++;
         end else begin
            m_op = '0;
            if (is_mt) begin
               m_op = funct; m_a = rs_val;
               if (funct == MTHI) m_hi = rs_val; else m_lo = rs_val;
            end else if (is_mul || div_go) begin
               m_op = funct; m_a = rs_val; m_b = rt_val;
               m_kind = is_mul ? 1 : 2; m_age = 1; m_evt = -1; m_vin = div_go;
               hilo_calc(funct, rs_val, rt_val, m_rhi, m_rlo);
            end else if (is_div) begin
               m_div0 = 1;
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
      @(posedge clk); #1;
      instr_valid = v; funct = f; rs_val = rs; rt_val = rt;
   endtask

   // Counts stalled cycles from the next negedge until release, bounded
   task automatic wait_idle(inout int n, input int budget, input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (stall && k < budget) begin n++; k++; @(negedge clk); end
      chk(tag, stall, 1'b0);
   endtask

   logic [5:0]  flist [9] = '{MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU, 6'h20};

   initial begin : stim
      int n, k;
      logic [5:0]  f;
      logic [31:0] a, b;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      chk("rst_opcode", hilo_opcode, 6'h00);
      chk("rst_stall", stall, 1'b0);
      chk("rst_vin", hilo_valid_in, 1'b0);
      chk("rst_tmo", timeout_err, 1'b0);
      @(posedge clk); #1 reset = 1'b0;

      // mthi then mfhi in the MTX cycle
      drive(1, MTHI, 32'h12345678, 32'h0);
      @(negedge clk); chk("mthi_stall", stall, 1'b0);
      drive(1, MFHI, 32'h0, 32'h0);
      @(negedge clk);
      chk("mtx_mfv", mf_valid, 1'b1);
      chk("mtx_mfhi", mf_data, 32'h12345678);
      chk("mtx_stall", stall, 1'b0);

      // multu 0xFFFFFFFF * 2
      drive(1, MULTU, 32'hFFFFFFFF, 32'd2);
      @(negedge clk); n = stall ? 1 : 0;
      drive(1, MFHI, 32'h0, 32'h0);
      wait_idle(n, 20, "mul_release");
      chk("mul_stall_len", n, 4);
      chk("mul_hi", mf_data, 32'h00000001);
      drive(1, MFLO, 32'h0, 32'h0);
      @(negedge clk); chk("mul_lo", mf_data, 32'hFFFFFFFE);

      // div -7 / 2 with unit done 4 cycles after the start pulse
      div_lat = 3;
      drive(1, DIV, 32'hFFFFFFF9, 32'd2);
      @(negedge clk); n = stall ? 1 : 0;
      drive(0, 6'h0, 32'h0, 32'h0);
      @(negedge clk); chk("div_vin", hilo_valid_in, 1'b1);
      n += stall ? 1 : 0;
      wait_idle(n, 80, "div_release");
      chk("div_stall_len", n, 8);
      drive(1, MFLO, 32'h0, 32'h0);
      @(negedge clk); chk("div_lo", mf_data, 32'hFFFFFFFD);
      drive(1, MFHI, 32'h0, 32'h0);
      @(negedge clk); chk("div_hi", mf_data, 32'hFFFFFFFF);

      // mflo held behind divu 100/7
      div_lat = 1;
      drive(1, DIVU, 32'd100, 32'd7);
      drive(1, MFLO, 32'h0, 32'h0);
      k = 0;
      @(negedge clk);
      while (stall && k < 60) begin chk("busy_mfv", mf_valid, 1'b0); k++; @(negedge clk); end
      chk("divu_release", stall, 1'b0);
      chk("divu_mfv", mf_valid, 1'b1);
      chk("divu_lo", mf_data, 32'd14);

      // Unit never answers: forced completion
      st_hang = 1'b1;
      drive(1, DIVU, 32'd5, 32'd1);
      @(negedge clk); n = stall ? 1 : 0;
      drive(0, 6'h0, 32'h0, 32'h0);
      wait_idle(n, 100, "tmo_release");
      chk("tmo_stall_len", n, 43);
      chk("tmo_flag", timeout_err, 1'b1);
      st_hang = 1'b0;

`ifdef MIPS_CPU_HILO_CTRL_DIV0_EN
      drive(1, DIVU, 32'd9, 32'd0);
      @(negedge clk); chk("div0_stall", stall, 1'b0);
      drive(0, 6'h0, 32'h0, 32'h0);
      @(negedge clk); chk("div0_set", div0_flag, 1'b1);
`endif

      // Reset in the middle of a div
      div_lat = 10;
      drive(1, DIV, 32'd50, 32'd5);
      drive(0, 6'h0, 32'h0, 32'h0);
      drive(0, 6'h0, 32'h0, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rstmid_opcode", hilo_opcode, 6'h00);
      chk("rstmid_stall", stall, 1'b0);
      chk("rstmid_tmo", timeout_err, 1'b0);

      // Random instruction stream; model checks every cycle
      for (int c = 0; c < 1500; c++) begin
         div_lat = $urandom_range(0, 5);
         f = flist[$urandom_range(0, 8)];
         a = $urandom;
         b = (($urandom & 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
`ifndef MIPS_CPU_HILO_CTRL_DIV0_EN
         if ((f == DIV || f == DIVU) && b == 32'd0) b = 32'd3;
`endif
         drive($urandom_range(0, 3) != 0, f, a, b);
      end
      drive(0, 6'h0, 32'h0, 32'h0);
      repeat (60) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end
endmodule
